// File: rtl/ariane_pkg.sv
// Shared frontend types: branch prediction metadata, fetch exceptions and the
// fetch-queue entry payload, plus the default fetch-queue depth.
package ariane_pkg;

    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    // Control-flow class attached to a predicted instruction
    typedef enum logic [1:0] {
        NoCF   = 2'd0,
        Branch = 2'd1,
        Jump   = 2'd2,
        Return = 2'd3
    } cf_t;

    typedef struct packed {
        cf_t         cf;
        logic [63:0] predict_address;
        logic        predict_taken;
        logic        valid;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    // One buffered instruction as handed from the expander to the decoder
    typedef struct packed {
        logic [63:0]        pc;
        logic [31:0]        instruction;
        logic [15:0]        compressed_instr;
        logic               is_compressed;
        logic               is_illegal;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_instr_queue_fifo_ctrl.sv
// Circular-buffer bookkeeping for the fetch queue: read/write pointers,
// occupancy counter and full/empty flags. Flush and reset both empty it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i             drop all entries at the next edge (wins over push/pop)
//   push_i, pop_i       accepted handshakes from the owner
//   full_c, empty_c     combinational status from registered count
//   wptr_o, rptr_o      registered pointers into storage
//   count_o             registered occupancy 0..DEPTH
module fifo_ctrl #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic             full_c,
    output logic             empty_c,
    output logic [PTR_W-1:0] wptr_o,
    output logic [PTR_W-1:0] rptr_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PTR_W'(1);
            if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_instr_queue.sv
// Elastic FIFO between the instruction realigner/expander and the decoder.
// Holds the entry storage and field packing; pointer/count control lives in
// fifo_ctrl. Output fields are a combinational view of the head entry.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush_i                   discard all entries (mispredict / redirect)
//   in_valid_i / in_ready_o   upstream handshake; in_* entry fields
//   out_valid_o / out_ready_i downstream handshake; out_* head entry fields
//   count_o                   current occupancy 0..DEPTH
module fetch_instr_queue
    import ariane_pkg::*;
#(
    parameter  int unsigned DEPTH = FETCH_QUEUE_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,

    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [63:0]        in_pc_i,
    input  logic [31:0]        in_instruction_i,
    input  logic [15:0]        in_compressed_instr_i,
    input  logic               in_is_compressed_i,
    input  logic               in_is_illegal_i,
    input  branchpredict_sbe_t in_branch_predict_i,
    input  exception_t         in_ex_i,

    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [63:0]        out_pc_o,
    output logic [31:0]        out_instruction_o,
    output logic [15:0]        out_compressed_instr_o,
    output logic               out_is_compressed_o,
    output logic               out_is_illegal_o,
    output branchpredict_sbe_t out_branch_predict_o,
    output exception_t         out_ex_o,

    output logic [CNT_W-1:0]   count_o
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     in_entry;
    fetch_entry_t     head;
    logic             full_c;
    logic             empty_c;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Handshakes depend only on registered state, never on out_ready_i
    assign in_ready_o  = !full_c && !rst;
    assign out_valid_o = !empty_c;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .full_c  (full_c),
        .empty_c (empty_c),
        .wptr_o  (wptr),
        .rptr_o  (rptr),
        .count_o (count_o)
    );

    always_comb begin
        in_entry                  = '0;
        in_entry.pc               = in_pc_i;
        in_entry.instruction      = in_instruction_i;
        in_entry.compressed_instr = in_compressed_instr_i;
        in_entry.is_compressed    = in_is_compressed_i;
        in_entry.is_illegal       = in_is_illegal_i;
        in_entry.branch_predict   = in_branch_predict_i;
        in_entry.ex               = in_ex_i;
    end

    // Storage: cleared on reset; a beat accepted during flush is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush_i) begin
            mem_q[wptr] <= in_entry;
        end
    end

    assign head                   = mem_q[rptr];
    assign out_pc_o               = head.pc;
    assign out_instruction_o      = head.instruction;
    assign out_compressed_instr_o = head.compressed_instr;
    assign out_is_compressed_o    = head.is_compressed;
    assign out_is_illegal_o       = head.is_illegal;
    assign out_branch_predict_o   = head.branch_predict;
    assign out_ex_o               = head.ex;

    // Protocol and occupancy invariants
    a_count_bound : assert property (@(posedge clk) count_o <= CNT_W'(DEPTH));
    a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full_c));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) !(pop && empty_c));
    a_head_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid_o && !out_ready_i && !flush_i) |=> $stable(head));

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Self-checking bench for fetch_instr_queue: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_fetch_instr_queue;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = FETCH_QUEUE_DEPTH;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    fetch_entry_t       in_e;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_pc;
    logic [31:0]        out_instruction;
    logic [15:0]        out_compressed_instr;
    logic               out_is_compressed;
    logic               out_is_illegal;
    branchpredict_sbe_t out_branch_predict;
    exception_t         out_ex;
    logic [CNT_W-1:0]   count;

    int checks   = 0;
    int failures = 0;

    fetch_entry_t model[$];

    always #5 clk = ~clk;

    fetch_instr_queue dut (
        .clk                    (clk),
        .rst                    (rst),
        .flush_i                (flush),
        .in_valid_i             (in_valid),
        .in_ready_o             (in_ready),
        .in_pc_i                (in_e.pc),
        .in_instruction_i       (in_e.instruction),
        .in_compressed_instr_i  (in_e.compressed_instr),
        .in_is_compressed_i     (in_e.is_compressed),
        .in_is_illegal_i        (in_e.is_illegal),
        .in_branch_predict_i    (in_e.branch_predict),
        .in_ex_i                (in_e.ex),
        .out_valid_o            (out_valid),
        .out_ready_i            (out_ready),
        .out_pc_o               (out_pc),
        .out_instruction_o      (out_instruction),
        .out_compressed_instr_o (out_compressed_instr),
        .out_is_compressed_o    (out_is_compressed),
        .out_is_illegal_o       (out_is_illegal),
        .out_branch_predict_o   (out_branch_predict),
        .out_ex_o               (out_ex),
        .count_o                (count)
    );

    function automatic fetch_entry_t rand_entry(input logic [63:0] pc);
        fetch_entry_t e;
        e.pc                             = pc;
        e.instruction                    = $urandom;
        e.compressed_instr               = 16'($urandom);
        e.is_compressed                  = 1'($urandom);
        e.is_illegal                     = 1'($urandom);
        e.branch_predict.cf              = cf_t'(2'($urandom));
        e.branch_predict.predict_address = {$urandom, $urandom};
        e.branch_predict.predict_taken   = 1'($urandom);
        e.branch_predict.valid           = 1'($urandom);
        e.ex.cause                       = {$urandom, $urandom};
        e.ex.tval                        = {$urandom, $urandom};
        e.ex.valid                       = 1'($urandom);
        return e;
    endfunction

    function automatic fetch_entry_t observed_head();
        fetch_entry_t e;
        e.pc               = out_pc;
        e.instruction      = out_instruction;
        e.compressed_instr = out_compressed_instr;
        e.is_compressed    = out_is_compressed;
        e.is_illegal       = out_is_illegal;
        e.branch_predict   = out_branch_predict;
        e.ex               = out_ex;
        return e;
    endfunction

    // One clock: model follows the queue rules (flush/reset empty it, pop
    // the oldest, append the accepted beat), sampled 1 time unit after edge
    task automatic tick();
        bit do_push;
        bit do_pop;
        do_push = in_valid && (model.size() != int'(DEPTH)) && !rst;
        do_pop  = (model.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (rst || flush) begin
            model.delete();
        end else begin
            if (do_pop)  void'(model.pop_front());
            if (do_push) model.push_back(in_e);
        end
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push_one(input fetch_entry_t e);
        in_valid = 1'b1;
        in_e     = e;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready_hi: got %b exp 0", in_ready);
        end
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_state: count %0d valid %b exp 0 0", count, out_valid);
        end
        checks++;
        if (observed_head() !== fetch_entry_t'('0)) begin
            failures++; $display("FAIL reset_fields: got %h exp 0", observed_head());
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready_lo: got %b exp 1", in_ready);
        end
    endtask

    task automatic test_single_push();
        fetch_entry_t e;
        idle();
        e = rand_entry(64'h8000_0000);
        e.instruction = 32'h0000_0013;
        push_one(e);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 || count !== CNT_W'(1)) begin
            failures++;
            $display("FAIL single_push: valid %b pc %h count %0d exp 1 80000000 1", out_valid, out_pc, count);
        end
        checks++;
        if (out_instruction !== 32'h0000_0013) begin
            failures++; $display("FAIL single_instr: got %h exp 00000013", out_instruction);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL single_drain: count %0d valid %b exp 0 0", count, out_valid);
        end
    endtask

    task automatic test_fill_drain();
        idle();
        for (int i = 0; i < 4; i++) push_one(rand_entry(64'h100 + 64'(4 * i)));
        checks++;
        if (count !== CNT_W'(4) || in_ready !== 1'b0) begin
            failures++; $display("FAIL fill: count %0d ready %b exp 4 0", count, in_ready);
        end
        push_one(rand_entry(64'h110));
        checks++;
        if (count !== CNT_W'(4) || out_pc !== 64'h100) begin
            failures++; $display("FAIL fifth_push: count %0d pc %h exp 4 100", count, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_pc !== 64'h100 + 64'(4 * i) || observed_head() !== model[0]) begin
                failures++; $display("FAIL drain_order%0d: pc %h exp %h", i, out_pc, 64'h100 + 64'(4 * i));
            end
            tick();
            checks++;
            if (count !== CNT_W'(3 - i)) begin
                failures++; $display("FAIL drain_count%0d: got %0d exp %0d", i, count, 3 - i);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        idle();
        push_one(rand_entry(64'h200));
        push_one(rand_entry(64'h204));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_e = rand_entry(64'h208 + 64'(4 * k));
            checks++;
            if (out_pc !== 64'h200 + 64'(4 * k) || out_valid !== 1'b1) begin
                failures++; $display("FAIL b2b_order%0d: pc %h exp %h", k, out_pc, 64'h200 + 64'(4 * k));
            end
            tick();
            checks++;
            if (count !== CNT_W'(2)) begin
                failures++; $display("FAIL b2b_count%0d: got %0d exp 2", k, count);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== '0) begin
            failures++; $display("FAIL b2b_drain: got %0d exp 0", count);
        end
    endtask

    task automatic test_flush();
        fetch_entry_t fresh;
        idle();
        for (int i = 0; i < 3; i++) push_one(rand_entry(64'h300 + 64'(4 * i)));
        in_valid  = 1'b1;
        in_e      = rand_entry(64'hDEAD_0000);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        idle();
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush: count %0d valid %b ready %b exp 0 0 1", count, out_valid, in_ready);
        end
        fresh = rand_entry(64'h400);
        push_one(fresh);
        checks++;
        if (count !== CNT_W'(1) || observed_head() !== fresh) begin
            failures++; $display("FAIL post_flush: count %0d pc %h exp 1 400", count, out_pc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_compressed_ex();
        fetch_entry_t a;
        fetch_entry_t b;
        idle();
        a = rand_entry(64'h500);
        a.is_compressed    = 1'b1;
        a.compressed_instr = 16'h4501;
        a.instruction      = 32'h0000_0513;
        b = rand_entry(64'h502);
        b.ex.valid = 1'b1;
        b.ex.cause = 64'd1;
        push_one(a);
        push_one(b);
        checks++;
        if (observed_head() !== a) begin
            failures++; $display("FAIL rvc_entry: got %h exp %h", observed_head(), a);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (observed_head() !== b || out_ex.valid !== 1'b1 || out_ex.cause !== 64'd1) begin
            failures++; $display("FAIL ex_entry: got %h exp %h", observed_head(), b);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_e      = rand_entry({$urandom, $urandom});
            checks++;
            if (count !== CNT_W'(model.size()) || out_valid !== (model.size() != 0)
                || in_ready !== (model.size() != int'(DEPTH))) begin
                failures++;
                $display("FAIL rand_state%0d: count %0d valid %b ready %b exp count %0d", c, count, out_valid, in_ready, model.size());
            end
            if (model.size() != 0) begin
                checks++;
                if (observed_head() !== model[0]) begin
                    failures++; $display("FAIL rand_head%0d: got %h exp %h", c, observed_head(), model[0]);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        push_one(rand_entry(64'h600));
        push_one(rand_entry(64'h604));
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL mid_rst_ready: got %b exp 0", in_ready);
        end
        tick();
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || out_pc !== 64'h0) begin
            failures++; $display("FAIL mid_rst: count %0d valid %b pc %h exp 0 0 0", count, out_valid, out_pc);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_rst_release: got %b exp 1", in_ready);
        end
    endtask

    initial begin
        rst  = 1'b1;
        in_e = '0;
        idle();
        test_reset();
        test_single_push();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_compressed_ex();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
